kds_controller: RTL
===================

# kds_controller

Sequencer for the kernel data store (KDS: 12 blocks × 3 FIFOs, depth 8). Sits between the input stream and the KDS control pins.
- Accepts 3-lane kernel words over a valid/ready handshake and steers each word into the selected block through one-hot `LE_select`.
- Then rotates all FIFOs for a commanded number of cycles via `cycle_enable`, or drains them via `only_readout`.
- Reports completion to the top-level control FSM.

## Interface
Parameters:
- `IO_DATA_WIDTH`, 16, lane width of v_1..v_3
- `NB_BLOCKS`, 12, number of KDS blocks (width of LE_select)
- `FIFO_DEPTH`, 8, words loaded per block / drain length
- `CYCLE_CNT_WIDTH`, 16, width of rotation count

Ports:
- `clk` in 1 — single clock, all state rising-edge
- `arst_n_in` in 1 — asynchronous reset, active low
- `start` in 1 — command pulse, sampled only in IDLE
- `readout` in 1 — command mode at start: 0 = load+cycle, 1 = drain
- `nb_cycles` in CYCLE_CNT_WIDTH — rotation count, latched at start
- `in_v1`, `in_v2`, `in_v3` in IO_DATA_WIDTH — input lanes
- `in_valid` in 1 / `in_ready` out 1 — input handshake
- `v_1`, `v_2`, `v_3` out IO_DATA_WIDTH — KDS data lanes
- `LE_select` out NB_BLOCKS — one-hot block write select
- `cycle_enable` out 1 — KDS rotate/read enable
- `only_readout` out 1 — KDS write inhibit
- `busy` out 1 — state != IDLE
- `done` out 1 — one-cycle completion pulse
- `abort` in 1 — only with KDS_CTRL_ABORT_EN

## Operation
FSM states: IDLE, LOAD, CYCLE, DRAIN, DONE. Counters: `blk_cnt` (0..NB_BLOCKS-1), `word_cnt` (0..FIFO_DEPTH-1), `cyc_cnt` (CYCLE_CNT_WIDTH).
- IDLE: all outputs 0. `start` && !`readout` → LOAD, clears blk/word counters, latches nb_cycles. `start` && `readout` → DRAIN, clears word_cnt.
- LOAD:
  - `in_ready`=1; `v_k` = `in_vk` combinationally.
  - `LE_select[blk_cnt]` = `in_valid`; other bits 0.
  - `cycle_enable`=0, `only_readout`=0.
  - Each accepted beat (in_valid && in_ready) increments word_cnt. Wrap at FIFO_DEPTH-1 → 0 and increments blk_cnt.
  - Beat accepted with blk_cnt=NB_BLOCKS-1 and word_cnt=FIFO_DEPTH-1 → CYCLE if latched count ≠ 0, else DONE.
  - `in_valid` gaps stall without side effects.
- CYCLE: `cycle_enable`=1, LE_select=0, in_ready=0. cyc_cnt increments per cycle. → DONE after exactly nb_cycles cycles in CYCLE.
- DRAIN: `cycle_enable`=1, `only_readout`=1, LE_select=0. → DONE after exactly FIFO_DEPTH cycles.
- DONE: `done`=1 for one cycle, busy still 1 → IDLE.
- `start` outside IDLE: ignored, no latching.
- LE_select is never asserted together with cycle_enable (KDS would write and rotate simultaneously).
- `v_1..v_3` = 0 outside LOAD.

## Timing
- Reset: state IDLE, all counters 0, every output 0 (in_ready, LE_select, cycle_enable, only_readout, busy, done, v_*). Reset mid-operation returns to IDLE immediately. No done pulse; KDS contents undefined.
- FIFO write occurs at the clock edge where LE_select bit and in_valid are high. Zero-latency pass-through from input to KDS.
- busy rises the cycle after start is sampled.
- Full load = NB_BLOCKS×FIFO_DEPTH accepted beats (96 default).
- Command latency = load beats + nb_cycles + 1 (DONE), or FIFO_DEPTH + 1 for drain.
- cyc_cnt compare is full width. nb_cycles = 2^CYCLE_CNT_WIDTH-1 is legal, no wrap.

## Configuration
- `KDS_CTRL_ABORT_EN` defined:
  - `abort` port present.
  - `abort`=1 in any state forces IDLE on the next edge, with all outputs 0 from that edge and no done pulse.
  - abort has priority over start and over all counter transitions.
- Undefined: port absent; commands always run to completion.

## Test plan
- Reset, then start (readout=0, nb_cycles=5), 96 back-to-back beats with value k on all lanes:
  - LE_select = 1<<0 for beats 0–7, 1<<1 for beats 8–15, … 1<<11 for beats 88–95.
  - Then cycle_enable high exactly 5 cycles, done pulse, busy low.
- Same with in_valid toggling 1/0 each cycle:
  - still 96 accepted beats, LE_select low on idle cycles, no extra counts.
- nb_cycles=0 → after beat 95 straight to DONE, cycle_enable never asserted.
- start with readout=1:
  - cycle_enable=only_readout=1 for exactly 8 cycles, then done.
  - in_ready and LE_select stay 0.
- start pulsed during LOAD and during CYCLE → ignored, sequence unchanged.
- arst_n_in low after beat 40 → all outputs 0 asynchronously, IDLE, no done. Fresh start reloads from block 0.
- With KDS_CTRL_ABORT_EN: abort in CYCLE after 2 of 10 cycles → cycle_enable low next edge, no done, busy 0.

Source files
------------

// File: rtl/kds_controller.sv
// -----------------------------------------------------------------------------
// kds_controller
//
// Sequencer for the kernel data store (KDS: NB_BLOCKS blocks x 3 FIFOs of
// depth FIFO_DEPTH). A command started from IDLE either loads one full KDS
// image from the input stream and then rotates all FIFOs for a commanded
// number of cycles, or drains the FIFOs for FIFO_DEPTH cycles.
//
// Ports:
//   clk, arst_n_in         : clock, asynchronous active-low reset
//   start, readout         : command pulse (sampled in IDLE) and mode
//                            (0 = load+cycle, 1 = drain)
//   nb_cycles              : rotation count, latched when a load command starts
//   in_v1..in_v3, in_valid : input kernel word lanes and valid
//   in_ready               : high while loading
//   v_1..v_3               : KDS data lanes (pass-through of the input in LOAD)
//   LE_select              : one-hot block write select
//   cycle_enable           : KDS rotate/read enable
//   only_readout           : KDS write inhibit (drain)
//   busy, done             : status, done is a one-cycle completion pulse
//   abort                  : present only when KDS_CTRL_ABORT_EN is defined
//
// Optional feature macro: KDS_CTRL_ABORT_EN (adds the abort input).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module kds_controller #(
  parameter int IO_DATA_WIDTH   = 16,
  parameter int NB_BLOCKS       = 12,
  parameter int FIFO_DEPTH      = 8,
  parameter int CYCLE_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       arst_n_in,
  input  logic                       start,
  input  logic                       readout,
  input  logic [CYCLE_CNT_WIDTH-1:0] nb_cycles,
  input  logic [IO_DATA_WIDTH-1:0]   in_v1,
  input  logic [IO_DATA_WIDTH-1:0]   in_v2,
  input  logic [IO_DATA_WIDTH-1:0]   in_v3,
  input  logic                       in_valid,
`ifdef KDS_CTRL_ABORT_EN
  input  logic                       abort,
`endif
  output logic                       in_ready,
  output logic [IO_DATA_WIDTH-1:0]   v_1,
  output logic [IO_DATA_WIDTH-1:0]   v_2,
  output logic [IO_DATA_WIDTH-1:0]   v_3,
  output logic [NB_BLOCKS-1:0]       LE_select,
  output logic                       cycle_enable,
  output logic                       only_readout,
  output logic                       busy,
  output logic                       done
);

  localparam int BLK_W  = (NB_BLOCKS  > 1) ? $clog2(NB_BLOCKS)  : 1;
  localparam int WORD_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [BLK_W-1:0]           BLK_LAST  = BLK_W'(NB_BLOCKS - 1);
  localparam logic [WORD_W-1:0]          WORD_LAST = WORD_W'(FIFO_DEPTH - 1);
  localparam logic [CYCLE_CNT_WIDTH-1:0] CYC_ONE   = CYCLE_CNT_WIDTH'(1'b1);
  localparam logic [NB_BLOCKS-1:0]       LE_ONE    = NB_BLOCKS'(1'b1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CYCLE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e                     state_q,        state_d;
  logic [BLK_W-1:0]           blk_cnt_q,      blk_cnt_d;
  logic [WORD_W-1:0]          word_cnt_q,     word_cnt_d;
  logic [CYCLE_CNT_WIDTH-1:0] cyc_cnt_q,      cyc_cnt_d;
  logic [CYCLE_CNT_WIDTH-1:0] nb_q,           nb_d;
  logic                       cycle_enable_q, cycle_enable_d;
  logic                       only_readout_q, only_readout_d;
  logic                       busy_q,         busy_d;
  logic                       done_q,         done_d;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d    = state_q;
    blk_cnt_d  = blk_cnt_q;
    word_cnt_d = word_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    nb_d       = nb_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (readout) begin
            state_d    = ST_DRAIN;
            word_cnt_d = {WORD_W{1'b0}};
          end else begin
            state_d    = ST_LOAD;
            blk_cnt_d  = {BLK_W{1'b0}};
            word_cnt_d = {WORD_W{1'b0}};
            nb_d       = nb_cycles;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        // in_ready is constantly high here, so in_valid alone marks a beat.
        if (in_valid) begin
          if (word_cnt_q == WORD_LAST) begin
            word_cnt_d = {WORD_W{1'b0}};
            if (blk_cnt_q == BLK_LAST) begin
              blk_cnt_d = {BLK_W{1'b0}};
              if (nb_q != {CYCLE_CNT_WIDTH{1'b0}}) begin
                state_d   = ST_CYCLE;
                cyc_cnt_d = {CYCLE_CNT_WIDTH{1'b0}};
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              blk_cnt_d = blk_cnt_q + BLK_W'(1'b1);
            end
          end else begin
            word_cnt_d = word_cnt_q + WORD_W'(1'b1);
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_CYCLE: begin
        // nb_q is nonzero here; comparing against nb_q-1 avoids any wrap
        // even for the all-ones count.
        if (cyc_cnt_q == (nb_q - CYC_ONE)) begin
          state_d = ST_DONE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_ONE;
        end
      end

      ST_DRAIN: begin
        if (word_cnt_q == WORD_LAST) begin
          state_d    = ST_DONE;
          word_cnt_d = {WORD_W{1'b0}};
        end else begin
          word_cnt_d = word_cnt_q + WORD_W'(1'b1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef KDS_CTRL_ABORT_EN
    // Abort overrides every transition computed above.
    if (abort) begin
      state_d    = ST_IDLE;
      blk_cnt_d  = {BLK_W{1'b0}};
      word_cnt_d = {WORD_W{1'b0}};
      cyc_cnt_d  = {CYCLE_CNT_WIDTH{1'b0}};
    end else begin
      state_d = state_d;
    end
`endif

    // Status outputs are decoded from the next state so they are registered
    // yet line up with the state they describe.
    cycle_enable_d = (state_d == ST_CYCLE) || (state_d == ST_DRAIN);
    only_readout_d = (state_d == ST_DRAIN);
    busy_d         = (state_d != ST_IDLE);
    done_d         = (state_d == ST_DONE);
  end

  // Zero-latency load path: lanes and block select follow the input while loading.
  always_comb begin
    in_ready  = 1'b0;
    LE_select = {NB_BLOCKS{1'b0}};
    v_1       = {IO_DATA_WIDTH{1'b0}};
    v_2       = {IO_DATA_WIDTH{1'b0}};
    v_3       = {IO_DATA_WIDTH{1'b0}};
    if (state_q == ST_LOAD) begin
      in_ready = 1'b1;
      v_1      = in_v1;
      v_2      = in_v2;
      v_3      = in_v3;
      if (in_valid) begin
        LE_select = LE_ONE << blk_cnt_q;
      end else begin
        LE_select = {NB_BLOCKS{1'b0}};
      end
    end else begin
      in_ready = 1'b0;
    end
  end

  // FSM state, counters and registered status outputs.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state_q        <= ST_IDLE;
      blk_cnt_q      <= {BLK_W{1'b0}};
      word_cnt_q     <= {WORD_W{1'b0}};
      cyc_cnt_q      <= {CYCLE_CNT_WIDTH{1'b0}};
      nb_q           <= {CYCLE_CNT_WIDTH{1'b0}};
      cycle_enable_q <= 1'b0;
      only_readout_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      blk_cnt_q      <= blk_cnt_d;
      word_cnt_q     <= word_cnt_d;
      cyc_cnt_q      <= cyc_cnt_d;
      nb_q           <= nb_d;
      cycle_enable_q <= cycle_enable_d;
      only_readout_q <= only_readout_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign cycle_enable = cycle_enable_q;
  assign only_readout = only_readout_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
